// File: rtl/acs_unit.sv
// rtl/acs_unit.sv - add-compare-select stage of the hard-decision Viterbi decoder
//
// Purpose: holds the path metric of every trellis state of the rate-1/3,
//   constraint-length K convolutional code. Each step adds the incoming
//   branch metrics to both predecessors of every next state, keeps the
//   smaller sum and emits the survivor decision vector. The unit accepts one
//   step per clock, normalizes the metrics and handles frame delimiting.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   bm_0 .. bm_7         2-bit branch metric against codeword value 0..7
//   bm_vld, sof, eof     step valid, first / last step of a frame
//   dec                  survivor decisions, bit n = predecessor p1 chosen for state n
//   dec_vld              dec valid
//   dec_sof, dec_eof     frame markers aligned with dec
//   best_state           index of the minimum new path metric
//   pm_norm              normalization applied on this step
//   drop_err             a step arrived outside a frame and was discarded
//
// Optional feature: define ACS_BEST_STATE_EN to build the minimum-metric
//   search behind best_state; otherwise best_state is tied to 0.

module acs_unit #(
  parameter int unsigned  K         = 7,
  parameter logic [K-1:0] G0        = 7'o133,
  parameter logic [K-1:0] G1        = 7'o171,
  parameter logic [K-1:0] G2        = 7'o165,
  parameter int unsigned  PM_W      = 8,
  parameter int unsigned  INIT_BIAS = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            bm_0,
  input  logic [1:0]            bm_1,
  input  logic [1:0]            bm_2,
  input  logic [1:0]            bm_3,
  input  logic [1:0]            bm_4,
  input  logic [1:0]            bm_5,
  input  logic [1:0]            bm_6,
  input  logic [1:0]            bm_7,
  input  logic                  bm_vld,
  input  logic                  sof,
  input  logic                  eof,
  output logic [2**(K-1)-1:0]   dec,
  output logic                  dec_vld,
  output logic                  dec_sof,
  output logic                  dec_eof,
  output logic [K-2:0]          best_state,
  output logic                  pm_norm,
  output logic                  drop_err
);

  localparam int unsigned     NS      = 2**(K-1);
  localparam int unsigned     SW      = K-1;
  localparam logic [PM_W-1:0] INIT_PM = PM_W'(INIT_BIAS);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  // Codeword bits {g0,g1,g2} for encoder register r = {u, s}. Called only
  // with loop-derived constant arguments, so it folds to constants.
  function automatic logic [2:0] codeword(input logic [K-1:0] r);
    return {^(r & G0), ^(r & G1), ^(r & G2)};
  endfunction

  logic [7:0][1:0] bm;
  assign bm = {bm_7, bm_6, bm_5, bm_4, bm_3, bm_2, bm_1, bm_0};

  state_t          state_q;
  logic [PM_W-1:0] pm_q   [NS];
  logic [PM_W-1:0] pm_old [NS];
  logic [PM_W-1:0] pm_sum [NS];
  logic [PM_W-1:0] pm_d   [NS];
  logic [NS-1:0]   dec_d;
  logic [NS-1:0]   dec_q;
  logic            all_msb;
  logic [SW-1:0]   best_d;
  logic [SW-1:0]   best_q;
  logic            dec_vld_q;
  logic            dec_sof_q;
  logic            dec_eof_q;
  logic            pm_norm_q;
  logic            drop_err_q;
  logic            drop;
  logic            accept;

  // A step outside a frame is discarded; everything else that is valid is processed.
  assign drop   = bm_vld & (state_q == IDLE) & ~sof;
  assign accept = bm_vld & ~drop;

  // A sof step starts from the initial metrics instead of the stored ones,
  // which also covers a mid-frame abort.
  always_comb begin
    for (int s = 0; s < NS; s++) begin
      if (sof) begin
        pm_old[s] = (s == 0) ? '0 : INIT_PM;
      end else begin
        pm_old[s] = pm_q[s];
      end
    end
  end

  // Add-compare-select for every next state.
  always_comb begin
    logic [SW-1:0]   nsv;
    logic [SW-1:0]   p0;
    logic [SW-1:0]   p1;
    logic [K-1:0]    r0;
    logic [K-1:0]    r1;
    logic [PM_W-1:0] c0;
    logic [PM_W-1:0] c1;
    logic            sel;
    nsv   = '0;
    p0    = '0;
    p1    = '0;
    r0    = '0;
    r1    = '0;
    c0    = '0;
    c1    = '0;
    sel   = 1'b0;
    dec_d = '0;
    for (int n = 0; n < NS; n++) begin
      nsv = SW'(n);
      p0  = {nsv[SW-2:0], 1'b0};
      p1  = {nsv[SW-2:0], 1'b1};
      // The input bit u is the MSB of the next state.
      r0  = {nsv[SW-1], p0};
      r1  = {nsv[SW-1], p1};
      c0  = pm_old[p0] + PM_W'(bm[codeword(r0)]);
      c1  = pm_old[p1] + PM_W'(bm[codeword(r1)]);
      // Ties keep p0.
      sel = (c1 < c0);
      dec_d[n]  = sel;
      pm_sum[n] = sel ? c1 : c0;
    end
  end

  // Once every metric has its MSB set, dropping the MSB subtracts the same
  // constant from all of them and keeps the sums from ever wrapping.
  always_comb begin
    all_msb = 1'b1;
    for (int n = 0; n < NS; n++) begin
      all_msb = all_msb & pm_sum[n][PM_W-1];
    end
    for (int n = 0; n < NS; n++) begin
      pm_d[n] = pm_sum[n];
      if (all_msb) begin
        pm_d[n][PM_W-1] = 1'b0;
      end
    end
  end

`ifdef ACS_BEST_STATE_EN
  // Strict less-than keeps the lowest index on ties.
  always_comb begin
    logic [PM_W-1:0] best_pm;
    best_pm = pm_d[0];
    best_d  = '0;
    for (int n = 1; n < NS; n++) begin
      if (pm_d[n] < best_pm) begin
        best_pm = pm_d[n];
        best_d  = SW'(n);
      end
    end
  end
`else
  assign best_d = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      for (int s = 0; s < NS; s++) begin
        pm_q[s] <= (s == 0) ? '0 : INIT_PM;
      end
      dec_q      <= '0;
      dec_vld_q  <= 1'b0;
      dec_sof_q  <= 1'b0;
      dec_eof_q  <= 1'b0;
      best_q     <= '0;
      pm_norm_q  <= 1'b0;
      drop_err_q <= 1'b0;
    end else begin
      // Step outputs are single-cycle and zero unless a step is processed.
      dec_q      <= '0;
      dec_vld_q  <= 1'b0;
      dec_sof_q  <= 1'b0;
      dec_eof_q  <= 1'b0;
      best_q     <= '0;
      pm_norm_q  <= 1'b0;
      drop_err_q <= drop;
      if (accept) begin
        for (int s = 0; s < NS; s++) begin
          pm_q[s] <= pm_d[s];
        end
        dec_q     <= dec_d;
        dec_vld_q <= 1'b1;
        dec_sof_q <= sof;
        dec_eof_q <= eof;
        best_q    <= best_d;
        pm_norm_q <= all_msb;
        // eof ends the frame from either state, including single-step and
        // abort-then-end steps.
        state_q   <= eof ? IDLE : RUN;
      end
    end
  end

  assign dec        = dec_q;
  assign dec_vld    = dec_vld_q;
  assign dec_sof    = dec_sof_q;
  assign dec_eof    = dec_eof_q;
  assign best_state = best_q;
  assign pm_norm    = pm_norm_q;
  assign drop_err   = drop_err_q;

endmodule

// File: doc/acs_unit.md
# acs_unit

Add-compare-select stage of the hard-decision Viterbi decoder. It sits directly downstream of the branch-distance unit and consumes its eight 2-bit Hamming branch metrics, one codeword per cycle. It keeps the path metric of every trellis state of the rate-1/3 convolutional code and emits one survivor-decision vector per step to the traceback unit. It sustains one step per clock, with path-metric normalization and frame delimiting.

## Interface
- `K`, 7: constraint length; number of states NS = 2^(K-1).
- `G0`, 7'o133: generator for codeword bit 2. Tap bit K-1 is the current input.
- `G1`, 7'o171: generator for codeword bit 1.
- `G2`, 7'o165: generator for codeword bit 0.
- `PM_W`, 8: path-metric width.
- `INIT_BIAS`, 64: initial metric of every state except state 0.

Ports:
- `clk`  in  1  working clock. One clock; reset is asynchronous and active-low.
- `rst_n`  in  1  asynchronous reset, active low.
- `bm_0` … `bm_7`  in  2 each  branch metric against codeword value 0…7.
- `bm_vld`  in  1  branch metrics valid.
- `sof`  in  1  first step of a frame; qualified by `bm_vld`.
- `eof`  in  1  last step of a frame; qualified by `bm_vld`.
- `dec`  out  NS  survivor decisions; bit n is the decision for next state n.
- `dec_vld`  out  1  `dec` valid.
- `dec_sof`, `dec_eof`  out  1  frame markers aligned with `dec`.
- `best_state`  out  K-1  index of the minimum new path metric.
- `pm_norm`  out  1  normalization applied on this step.
- `drop_err`  out  1  a step was dropped outside a frame.

## Operation
- **Trellis convention**
  - State s = {u[t-1] … u[t-K+1]}, with u[t-1] as the MSB.
  - Next state ns = {u, s[K-2:1]}; the input bit is u = ns[K-2].
  - Predecessors: p0 = {ns[K-3:0],0} and p1 = {ns[K-3:0],1}.
  - Encoder register r = {u, s}. Each codeword bit is ^(r & Gi), packed as {g0,g1,g2} to index `bm_*`. All codewords are parameter-derived constants.
- **ACS, per ns**
  - c0 = pm[p0] + bm[cw(p0,u)] and c1 = pm[p1] + bm[cw(p1,u)].
  - Select p1 only if c1 < c0; ties select p0. Set dec[ns] = 1 when p1 is selected.
  - Sums are PM_W-bit and never wrap, because of normalization.
- **Normalization**
  - If every new metric has bit PM_W-1 set, clear that bit in all of them and pulse `pm_norm`.
- **Initialization**
  - Applies on reset and on every `sof` step.
  - The step's "old" metrics are pm[0] = 0 and all others = INIT_BIAS, replacing the stored values.
- **FSM**
  - States are IDLE and RUN; reset enters IDLE.
  - IDLE + `bm_vld` & `sof`: process the step and go to RUN. If `eof` is also set, stay in IDLE (single-step frame).
  - IDLE + `bm_vld` & !`sof`: drop the step. No `dec_vld`; pulse `drop_err` for 1 cycle.
  - RUN + `bm_vld`: process the step. If `eof`, go to IDLE.
  - RUN + `bm_vld` & `sof`: abort the current frame, re-initialize, and stay in RUN with `dec_sof` = 1.
  - Cycles without `bm_vld` hold metrics and state.
- **Reset values**
  - All outputs are 0.
  - pm[0] = 0; every other pm = INIT_BIAS.
  - FSM is in IDLE.
  - Assertion mid-frame discards the frame immediately.

## Timing
- Latency is 1 cycle: `dec`, `dec_vld`, `dec_sof`, `dec_eof`, `pm_norm`, `best_state` and `drop_err` are registered on the edge that samples `bm_vld`.
- Path metrics update on the same edge, so back-to-back `bm_vld` is accepted every cycle with no backpressure.
- When `dec_vld` = 0, `dec`, the frame markers, `best_state` and `pm_norm` are 0.

## Configuration
- `ACS_BEST_STATE_EN`, when defined:
  - `best_state` is computed from the post-normalization new metrics.
  - It holds the lowest index on ties and is registered with `dec`.
- When undefined:
  - No minimum-search logic is built and `best_state` is tied to 0.
  - All other behaviour is unchanged.

## Test plan
- **Reset:**
  - Stimulus: hold `rst_n` = 0, then release.
  - Response: all outputs 0, FSM in IDLE.
  - Response: the first step after `sof` uses pm[0] = 0 and the others = 64.
- **All-zero stream:**
  - Stimulus: `sof`, then 64 steps with bm_0..7 = 0,1,1,2,1,2,2,3, `eof` on the last.
  - Response: 64 consecutive `dec_vld` with `dec` = 0, `best_state` = 0.
  - Response: `dec_sof` on the first output, `dec_eof` on the last.
- **Normalization:**
  - Stimulus: `sof`, then all bm = 3 continuously.
  - Response: `dec` = 0 every step.
  - Response: steps 6–42 leave every pm at 3k.
  - Response: step 43 pulses `pm_norm` and leaves every pm at 1.
- **Drop:**
  - Stimulus: `bm_vld` without `sof` while in IDLE.
  - Response: `dec_vld` = 0, `drop_err` = 1 for 1 cycle, metrics unchanged.
- **Single-step and abort:**
  - Stimulus: `sof` & `eof` in the same cycle.
  - Response: one output with `dec_sof` = `dec_eof` = 1, FSM back in IDLE.
  - Stimulus: `sof` mid-frame.
  - Response: metrics re-initialized, `dec_sof` = 1.
- **Best state (`ACS_BEST_STATE_EN`):**
  - Stimulus: `sof` with received codeword 111 (bm_0..7 = 3,2,2,1,2,1,1,0).
  - Response with the macro: `best_state` = 32.
  - Response without the macro: `best_state` = 0.
